// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures the EX-stage instruction on each rising edge. Memory and
// writeback controls are qualified as they are captured. A taken branch is
// resolved at capture time and drives a one-cycle redirect pulse.
// Edge priority: reset > flush > stall > capture.
// Interface note: there is no valid/ready handshake on this block. Upstream
// holds or replaces the EX instruction through stall and flush. ex_valid
// marks a real instruction, and mem_valid marks the same for the MEM stage.
module ex_mem_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] store_data,
  input  logic [4:0]  write_reg,
  input  logic [31:0] branch_target,
  input  logic        ctl_reg_write,
  input  logic        ctl_mem_to_reg,
  input  logic        ctl_mem_read,
  input  logic        ctl_mem_write,
  input  logic        ctl_beq,
  input  logic        ctl_bne,
  output logic        mem_valid,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_write_reg,
  output logic        mem_reg_write,
  output logic        mem_mem_to_reg,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        fwd_en,
  output logic [31:0] retired_count
);

  logic capture;
  logic cap_reg_write;
  logic cap_mem_to_reg;
  logic cap_mem_read;
  logic cap_mem_write;
  logic taken;

  // Qualify controls with validity. r0 is never written. A simultaneous
  // read and write decodes as a load.
  always_comb begin
    capture        = ~flush & ~stall;
    cap_reg_write  = ex_valid & ctl_reg_write & (write_reg != 5'd0);
    cap_mem_to_reg = ex_valid & ctl_mem_to_reg;
    cap_mem_read   = ex_valid & ctl_mem_read;
    cap_mem_write  = ex_valid & ctl_mem_write & ~ctl_mem_read;
    // beq and bne together is an illegal decode, so it is treated as not taken.
    taken          = ex_valid & ~(ctl_beq & ctl_bne) &
                     ((ctl_beq & alu_zero) | (ctl_bne & ~alu_zero));
  end

  // Valid bit and controls: flush inserts a bubble, stall holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_reg_write  <= cap_reg_write;
      mem_mem_to_reg <= cap_mem_to_reg;
      mem_mem_read   <= cap_mem_read;
      mem_mem_write  <= cap_mem_write;
    end
  end

  // Datapath registers load only on capture. Under a flush their contents
  // are irrelevant because mem_valid is low, so they are left unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_alu_result <= 32'd0;
      mem_store_data <= 32'd0;
      mem_write_reg  <= 5'd0;
    end else if (capture) begin
      mem_alu_result <= alu_result;
      mem_store_data <= store_data;
      mem_write_reg  <= write_reg;
    end
  end

  // Redirect pulse. Any non-capture edge clears it, so a held branch
  // never repeats its redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_src    <= 1'b0;
      pc_target <= 32'd0;
    end else if (capture) begin
      pc_src <= taken;
      if (taken) begin
        pc_target <= branch_target;
      end
    end else begin
      pc_src <= 1'b0;
    end
  end

  // Count every real instruction captured. The counter wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count <= 32'd0;
    end else if (capture && ex_valid) begin
      retired_count <= retired_count + 32'd1;
    end
  end

  // Loads are not forwardable from this stage because their data is not
  // available until after memory access.
  always_comb begin
    fwd_en = mem_valid & mem_reg_write & ~mem_mem_read;
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Table-driven self-checking bench for ex_mem_reg.
module tb_ex_mem_reg;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] store_data;
  logic [4:0]  write_reg;
  logic [31:0] branch_target;
  logic        ctl_reg_write;
  logic        ctl_mem_to_reg;
  logic        ctl_mem_read;
  logic        ctl_mem_write;
  logic        ctl_beq;
  logic        ctl_bne;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_store_data;
  logic [4:0]  mem_write_reg;
  logic        mem_reg_write;
  logic        mem_mem_to_reg;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        fwd_en;
  logic [31:0] retired_count;

  ex_mem_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .alu_result(alu_result), .alu_zero(alu_zero),
    .store_data(store_data), .write_reg(write_reg),
    .branch_target(branch_target), .ctl_reg_write(ctl_reg_write),
    .ctl_mem_to_reg(ctl_mem_to_reg), .ctl_mem_read(ctl_mem_read),
    .ctl_mem_write(ctl_mem_write), .ctl_beq(ctl_beq), .ctl_bne(ctl_bne),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_write_reg(mem_write_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .pc_src(pc_src), .pc_target(pc_target), .fwd_en(fwd_en),
    .retired_count(retired_count)
  );

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        ev;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic [31:0] bt;
    logic        rw, m2r, mr, mw, beq, bne;
  } in_t;

  typedef struct packed {
    logic        v;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        rw, m2r, mr, mw, pcs;
    logic [31:0] pct;
    logic        fwd;
    logic [31:0] cnt;
    logic        dchk;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam int EW = $bits(exp_t);
  localparam int NV = 15;

  logic [EW-1:0] exp_q[$];
  vec_t          vecs[NV];
  int            n_cmp = 0;
  int            n_fail = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic in_t mk_in(input logic s, input logic f, input logic ev,
                                input logic [31:0] alu, input logic z,
                                input logic [31:0] sd, input logic [4:0] wr,
                                input logic [31:0] bt, input logic rw,
                                input logic m2r, input logic mr, input logic mw,
                                input logic beq, input logic bne);
    in_t r;
    r.stall = s; r.flush = f; r.ev = ev; r.alu = alu; r.zero = z; r.sd = sd;
    r.wr = wr; r.bt = bt; r.rw = rw; r.m2r = m2r; r.mr = mr; r.mw = mw;
    r.beq = beq; r.bne = bne;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic v, input logic [31:0] alu,
                                  input logic [31:0] sd, input logic [4:0] wr,
                                  input logic rw, input logic m2r, input logic mr,
                                  input logic mw, input logic pcs,
                                  input logic [31:0] pct, input logic fwd,
                                  input logic [31:0] cnt, input logic dchk);
    exp_t r;
    r.v = v; r.alu = alu; r.sd = sd; r.wr = wr; r.rw = rw; r.m2r = m2r;
    r.mr = mr; r.mw = mw; r.pcs = pcs; r.pct = pct; r.fwd = fwd; r.cnt = cnt;
    r.dchk = dchk;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t i);
    stall = i.stall; flush = i.flush; ex_valid = i.ev; alu_result = i.alu;
    alu_zero = i.zero; store_data = i.sd; write_reg = i.wr;
    branch_target = i.bt; ctl_reg_write = i.rw; ctl_mem_to_reg = i.m2r;
    ctl_mem_read = i.mr; ctl_mem_write = i.mw; ctl_beq = i.beq; ctl_bne = i.bne;
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_head(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_queue: got empty expected entry", tag);
      return;
    end
    e = exp_t'(exp_q.pop_front());
    chk({tag, "_valid"}, 32'(mem_valid), 32'(e.v));
    chk({tag, "_reg_write"}, 32'(mem_reg_write), 32'(e.rw));
    chk({tag, "_mem_to_reg"}, 32'(mem_mem_to_reg), 32'(e.m2r));
    chk({tag, "_mem_read"}, 32'(mem_mem_read), 32'(e.mr));
    chk({tag, "_mem_write"}, 32'(mem_mem_write), 32'(e.mw));
    chk({tag, "_pc_src"}, 32'(pc_src), 32'(e.pcs));
    chk({tag, "_pc_target"}, pc_target, e.pct);
    chk({tag, "_fwd_en"}, 32'(fwd_en), 32'(e.fwd));
    chk({tag, "_count"}, retired_count, e.cnt);
    if (e.dchk) begin
      chk({tag, "_alu_result"}, mem_alu_result, e.alu);
      chk({tag, "_store_data"}, mem_store_data, e.sd);
      chk({tag, "_write_reg"}, 32'(mem_write_reg), 32'(e.wr));
    end
  endtask

  // Called at a falling edge: drive, record expectation, sample after edge.
  task automatic step(input string tag, input in_t i, input exp_t e);
    drive(i);
    exp_q.push_back(EW'(e));
    @(posedge clk);
    #1;
    compare_head(tag);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges, checked before any edge.
  task automatic async_reset(input string tag);
    exp_t z;
    z = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    reset = 1'b1;
    #1;
    exp_q.push_back(EW'(z));
    compare_head(tag);
    reset = 1'b0;
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{mk_in(0,0,1,32'h10,0,32'hAAAA0001,5,0,1,0,0,0,0,0),
                 mk_exp(1,32'h10,32'hAAAA0001,5,1,0,0,0,0,0,1,1,1)};
    vecs[1]  = '{mk_in(0,0,1,0,1,32'h22,0,32'h00400020,0,0,0,0,1,0),
                 mk_exp(1,0,32'h22,0,0,0,0,0,1,32'h00400020,0,2,1)};
    vecs[2]  = '{mk_in(0,0,1,32'h30,1,32'h33,7,32'h00500000,1,0,0,0,0,1),
                 mk_exp(1,32'h30,32'h33,7,1,0,0,0,0,32'h00400020,1,3,1)};
    vecs[3]  = '{mk_in(0,0,1,32'h4,0,32'h44,8,32'h00600040,0,0,0,0,0,1),
                 mk_exp(1,32'h4,32'h44,8,0,0,0,0,1,32'h00600040,0,4,1)};
    vecs[4]  = '{mk_in(0,0,1,0,1,32'h55,9,32'h00700000,1,0,0,0,1,1),
                 mk_exp(1,0,32'h55,9,1,0,0,0,0,32'h00600040,1,5,1)};
    vecs[5]  = '{mk_in(0,0,1,32'h66,0,32'h66,0,0,1,0,0,0,0,0),
                 mk_exp(1,32'h66,32'h66,0,0,0,0,0,0,32'h00600040,0,6,1)};
    vecs[6]  = '{mk_in(0,0,0,32'h77,0,32'h77,3,0,1,0,0,1,0,0),
                 mk_exp(0,32'h77,32'h77,3,0,0,0,0,0,32'h00600040,0,6,1)};
    vecs[7]  = '{mk_in(0,0,1,32'h1000,0,32'h88,10,0,1,1,1,0,0,0),
                 mk_exp(1,32'h1000,32'h88,10,1,1,1,0,0,32'h00600040,0,7,1)};
    vecs[8]  = '{mk_in(0,0,1,32'h2000,0,32'h99,11,0,0,0,1,1,0,0),
                 mk_exp(1,32'h2000,32'h99,11,0,0,1,0,0,32'h00600040,0,8,1)};
    vecs[9]  = '{mk_in(0,0,1,32'h3000,0,32'hDEADBEEF,12,0,0,0,0,1,0,0),
                 mk_exp(1,32'h3000,32'hDEADBEEF,12,0,0,0,1,0,32'h00600040,0,9,1)};
    vecs[10] = '{mk_in(1,0,1,32'hBAD,1,32'hBAD,1,32'h1234,1,0,0,0,1,0),
                 mk_exp(1,32'h3000,32'hDEADBEEF,12,0,0,0,1,0,32'h00600040,0,9,1)};
    vecs[11] = '{mk_in(0,1,1,32'hBAD,1,32'hBAD,2,32'h1234,1,0,0,0,1,0),
                 mk_exp(0,0,0,0,0,0,0,0,0,32'h00600040,0,9,0)};
    vecs[12] = '{mk_in(0,0,1,32'h13,1,32'h13,13,32'h00800000,1,0,0,0,1,0),
                 mk_exp(1,32'h13,32'h13,13,1,0,0,0,1,32'h00800000,1,10,1)};
    vecs[13] = '{mk_in(1,1,1,32'hBAD,1,32'hBAD,4,32'h1234,1,0,0,0,1,0),
                 mk_exp(0,0,0,0,0,0,0,0,0,32'h00800000,0,10,0)};
    vecs[14] = '{mk_in(0,0,0,0,1,0,0,32'h00900000,1,0,0,0,1,0),
                 mk_exp(0,0,0,0,0,0,0,0,0,32'h00800000,0,10,1)};

    // Reset state is visible before any clock edge.
    drive(mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    reset = 1'b1;
    #1;
    exp_q.push_back(EW'(mk_exp(0,0,0,0,0,0,0,0,0,0,0,0,1)));
    compare_head("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      step($sformatf("vec%0d", k), vecs[k].i, vecs[k].e);
    end

    // Taken branch, then held for three cycles: one pulse only, state frozen.
    step("stall_cap", mk_in(0,0,1,32'h40,1,32'h41,6,32'h00A00000,1,0,0,0,1,0),
         mk_exp(1,32'h40,32'h41,6,1,0,0,0,1,32'h00A00000,1,11,1));
    for (int k = 0; k < 3; k++) begin
      step($sformatf("stall%0d", k),
           mk_in(1,0,1,32'h99,1,32'h98,7,32'h00B00000,1,0,0,0,1,0),
           mk_exp(1,32'h40,32'h41,6,1,0,0,0,0,32'h00A00000,1,11,1));
    end

    // Counter wrap from all-ones.
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    #1;
    chk("wrap_preload", retired_count, 32'hFFFF_FFFF);
    step("wrap", mk_in(0,0,1,32'h50,0,32'h51,2,0,0,0,0,0,0,0),
         mk_exp(1,32'h50,32'h51,2,0,0,0,0,0,32'h00A00000,0,0,1));

    // Async reset while a redirect pulse and a valid instruction are live.
    step("pre_rst", mk_in(0,0,1,32'h60,1,32'h61,9,32'h00C00000,1,0,0,0,1,0),
         mk_exp(1,32'h60,32'h61,9,1,0,0,0,1,32'h00C00000,1,1,1));
    async_reset("async_rst");
    step("post_rst", mk_in(0,0,1,32'h70,0,32'h71,3,0,1,0,0,0,0,0),
         mk_exp(1,32'h70,32'h71,3,1,0,0,0,0,0,1,1,1));

    // Reset during a stall discards the held pulse and count.
    step("pre_stall_rst", mk_in(0,0,1,32'h80,1,32'h81,4,32'h00D00000,0,0,0,0,1,0),
         mk_exp(1,32'h80,32'h81,4,0,0,0,0,1,32'h00D00000,0,2,1));
    drive(mk_in(1,0,1,32'h90,1,32'h91,5,32'h00E00000,1,0,0,0,1,0));
    async_reset("stall_rst");
    step("stall_after_rst", mk_in(1,0,1,32'h90,1,32'h91,5,32'h00E00000,1,0,0,0,1,0),
         mk_exp(0,0,0,0,0,0,0,0,0,0,0,0,1));
    step("resume", mk_in(0,0,1,32'hA0,1,32'hA1,5,32'h00E00000,1,0,0,0,1,0),
         mk_exp(1,32'hA0,32'hA1,5,1,0,0,0,1,32'h00E00000,1,1,1));

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
